apb_master: RTL and testbench

- APB3 initiator (requester) bridge that converts a simple valid/ready request/response interface into APB transfers.
- Sits between a core-side or bus-side client and APB peripherals such as gpio; it drives PSEL, PENABLE, PADDR, PWRITE and PWDATA, and samples PREADY, PRDATA and PSLVERR.
- Handles one transfer at a time. A one-deep response register holds the result until the client accepts it.

---
 rtl/apb_master.sv | 170 +++++++++++++++++
 tb/tb_apb_master.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB3 requester: turns a valid/ready request into one APB transfer and holds the result in a one-deep response register.
// Optional ACCESS-phase timeout abort is built when APB_MASTER_TIMEOUT_EN is defined.
module apb_master #(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic                  req_write,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic                  PSEL,
   output logic                  PENABLE,
   output logic [ADDR_WIDTH-1:0] PADDR,
   output logic                  PWRITE,
   output logic [DATA_WIDTH-1:0] PWDATA,
   input  logic [DATA_WIDTH-1:0] PRDATA,
   input  logic                  PREADY,
   input  logic                  PSLVERR
);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

   state_t                state_reg, state_next;
   logic                  psel_reg, psel_next;
   logic                  penable_reg, penable_next;
   logic [ADDR_WIDTH-1:0] paddr_reg, paddr_next;
   logic                  pwrite_reg, pwrite_next;
   logic [DATA_WIDTH-1:0] pwdata_reg, pwdata_next;
   logic                  rsp_valid_reg, rsp_valid_next;
   logic [DATA_WIDTH-1:0] rsp_rdata_reg, rsp_rdata_next;
   logic                  rsp_err_reg, rsp_err_next;
   logic                  accept;
   logic                  timeout_hit;

   assign req_ready = (state_reg == IDLE) && !rst;
   assign accept    = req_valid && req_ready;

`ifdef APB_MASTER_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [TO_W-1:0] cnt_reg, cnt_next;

   // Counter holds the number of wait edges already seen; the edge that would
   // bring it to TIMEOUT_CYCLES ends the final allowed ACCESS cycle.
   assign timeout_hit = (state_reg == ACCESS) && !PREADY &&
                        (cnt_reg == TO_W'(TIMEOUT_CYCLES - 1));

   always_comb begin
      cnt_next = cnt_reg;
      if (state_reg == SETUP) begin
         cnt_next = '0;
      end else if (state_reg == ACCESS && !PREADY && !timeout_hit) begin
         cnt_next = cnt_reg + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end
`else
   assign timeout_hit = 1'b0;
`endif

   // State and registered outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         psel_reg      <= 1'b0;
         penable_reg   <= 1'b0;
         paddr_reg     <= '0;
         pwrite_reg    <= 1'b0;
         pwdata_reg    <= '0;
         rsp_valid_reg <= 1'b0;
         rsp_rdata_reg <= '0;
         rsp_err_reg   <= 1'b0;
      end else begin
         state_reg     <= state_next;
         psel_reg      <= psel_next;
         penable_reg   <= penable_next;
         paddr_reg     <= paddr_next;
         pwrite_reg    <= pwrite_next;
         pwdata_reg    <= pwdata_next;
         rsp_valid_reg <= rsp_valid_next;
         rsp_rdata_reg <= rsp_rdata_next;
         rsp_err_reg   <= rsp_err_next;
      end
   end

   // Next-state logic
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (accept) state_next = SETUP;
         SETUP:   state_next = ACCESS;
         ACCESS:  if (PREADY || timeout_hit) state_next = RESP;
         RESP:    if (rsp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs
   always_comb begin
      psel_next      = psel_reg;
      penable_next   = penable_reg;
      paddr_next     = paddr_reg;
      pwrite_next    = pwrite_reg;
      pwdata_next    = pwdata_reg;
      rsp_valid_next = rsp_valid_reg;
      rsp_rdata_next = rsp_rdata_reg;
      rsp_err_next   = rsp_err_reg;
      case (state_reg)
         IDLE: begin
            if (accept) begin
               paddr_next   = req_addr;
               pwrite_next  = req_write;
               pwdata_next  = req_wdata;
               psel_next    = 1'b1;
               penable_next = 1'b0;
            end
         end
         SETUP: begin
            penable_next = 1'b1;
         end
         ACCESS: begin
            // Normal completion wins over a timeout landing on the same edge.
            if (PREADY) begin
               rsp_rdata_next = pwrite_reg ? '0 : PRDATA;
               rsp_err_next   = PSLVERR;
               rsp_valid_next = 1'b1;
               psel_next      = 1'b0;
               penable_next   = 1'b0;
            end else if (timeout_hit) begin
               rsp_rdata_next = '0;
               rsp_err_next   = 1'b1;
               rsp_valid_next = 1'b1;
               psel_next      = 1'b0;
               penable_next   = 1'b0;
            end
         end
         RESP: begin
            if (rsp_ready) rsp_valid_next = 1'b0;
         end
         default: begin
            psel_next    = 1'b0;
            penable_next = 1'b0;
         end
      endcase
   end

   assign PSEL      = psel_reg;
   assign PENABLE   = penable_reg;
   assign PADDR     = paddr_reg;
   assign PWRITE    = pwrite_reg;
   assign PWDATA    = pwdata_reg;
   assign rsp_valid = rsp_valid_reg;
   assign rsp_rdata = rsp_rdata_reg;
   assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_apb_master.sv
// Directed bench for apb_master: write, wait-state read, slave error, response backpressure, mid-transfer reset, timeout.
module tb_apb_master;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [31:0] rsp_rdata;
   logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
   logic [31:0] PADDR, PWDATA, PRDATA;

   int tests = 0;
   int fails = 0;

   apb_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
      .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
      .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
      rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
      tick(); tick();
      check("rst_req_ready", {31'd0, req_ready}, 32'd0);
      check("rst_psel", {31'd0, PSEL}, 32'd0);
      check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst_paddr", PADDR, 32'd0);
      rst = 1'b0;
      #1;
      check("idle_req_ready", {31'd0, req_ready}, 32'd1);

      // Write, no wait states
      $display("[TB] write 93000000 <- ffffffff, zero wait");
      PREADY = 1'b1;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h9300_0000; req_wdata = 32'hFFFF_FFFF;
      tick();
      req_valid = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      check("w_c1_psel", {31'd0, PSEL}, 32'd1);
      check("w_c1_penable", {31'd0, PENABLE}, 32'd0);
      check("w_c1_paddr", PADDR, 32'h9300_0000);
      check("w_c1_pwdata", PWDATA, 32'hFFFF_FFFF);
      check("w_c1_pwrite", {31'd0, PWRITE}, 32'd1);
      tick();
      check("w_c2_penable", {31'd0, PENABLE}, 32'd1);
      check("w_c2_paddr", PADDR, 32'h9300_0000);
      check("w_c2_pwdata", PWDATA, 32'hFFFF_FFFF);
      check("w_c2_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("w_c3_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("w_c3_rsp_err", {31'd0, rsp_err}, 32'd0);
      check("w_c3_rsp_rdata", rsp_rdata, 32'd0);
      check("w_c3_psel", {31'd0, PSEL}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("w_done_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("w_done_req_ready", {31'd0, req_ready}, 32'd1);

      // Read, 3 wait states
      $display("[TB] read 93000008, 3 wait states");
      PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9300_0008; req_wdata = 32'h1111_2222;
      tick();
      req_valid = 1'b0;
      check("r_c1_psel", {31'd0, PSEL}, 32'd1);
      check("r_c1_pwrite", {31'd0, PWRITE}, 32'd0);
      check("r_c1_pwdata", PWDATA, 32'h1111_2222);
      tick();
      check("r_c2_penable", {31'd0, PENABLE}, 32'd1);
      tick();
      check("r_c3_penable", {31'd0, PENABLE}, 32'd1);
      tick();
      check("r_c4_penable", {31'd0, PENABLE}, 32'd1);
      check("r_c4_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      tick();
      check("r_c5_penable", {31'd0, PENABLE}, 32'd1);
      check("r_c5_paddr", PADDR, 32'h9300_0008);
      PREADY = 1'b1; PRDATA = 32'hA5A5_0001;
      tick();
      PREADY = 1'b0; PRDATA = 32'h0;
      check("r_c6_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("r_c6_rsp_rdata", rsp_rdata, 32'hA5A5_0001);
      check("r_c6_penable", {31'd0, PENABLE}, 32'd0);
      check("r_c6_paddr_hold", PADDR, 32'h9300_0008);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Write with slave error
      $display("[TB] write 93000010 with PSLVERR");
      PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h5555_AAAA;
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h9300_0010; req_wdata = 32'h0000_00FF;
      tick();
      req_valid = 1'b0;
      tick(); tick();
      PSLVERR = 1'b0;
      check("e_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("e_rsp_err", {31'd0, rsp_err}, 32'd1);
      check("e_rsp_rdata", rsp_rdata, 32'd0);
      check("e_req_ready_resp", {31'd0, req_ready}, 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("e_idle_req_ready", {31'd0, req_ready}, 32'd1);

      // Response backpressure with req_valid held
      $display("[TB] read 93000020, rsp_ready held low 5 cycles");
      PREADY = 1'b1; PRDATA = 32'h1234_5678;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9300_0020;
      tick(); tick(); tick();
      PRDATA = 32'h0;
      for (int i = 0; i < 5; i++) begin
         check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
         check("bp_rsp_rdata", rsp_rdata, 32'h1234_5678);
         check("bp_req_ready", {31'd0, req_ready}, 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      req_addr = 32'h9300_0024;
      tick();
      rsp_ready = 1'b0;
      check("bp_hs_req_ready", {31'd0, req_ready}, 32'd1);
      check("bp_hs_psel", {31'd0, PSEL}, 32'd0);
      tick();
      req_valid = 1'b0;
      check("bp_next_psel", {31'd0, PSEL}, 32'd1);
      check("bp_next_paddr", PADDR, 32'h9300_0024);
      tick(); tick();
      check("bp_next_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;

      // Reset in the second ACCESS wait cycle
      $display("[TB] read 93000030, reset during wait");
      PREADY = 1'b0;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9300_0030;
      tick();
      req_valid = 1'b0;
      tick(); tick();
      check("rr_penable_before", {31'd0, PENABLE}, 32'd1);
      rst = 1'b1;
      #1;
      check("rr_req_ready_rst", {31'd0, req_ready}, 32'd0);
      tick();
      check("rr_psel", {31'd0, PSEL}, 32'd0);
      check("rr_penable", {31'd0, PENABLE}, 32'd0);
      check("rr_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      rst = 1'b0;
      PREADY = 1'b1;
      #1;
      check("rr_req_ready_after", {31'd0, req_ready}, 32'd1);
      tick(); tick();
      check("rr_rsp_valid_later", {31'd0, rsp_valid}, 32'd0);

      // PREADY stuck low
      $display("[TB] read 93000040, PREADY stuck low");
      PREADY = 1'b0; PRDATA = 32'hCAFE_F00D;
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h9300_0040;
      tick();
      req_valid = 1'b0;
      tick();
`ifdef APB_MASTER_TIMEOUT_EN
      for (int i = 0; i < 16; i++) begin
         check("to_penable_wait", {31'd0, PENABLE}, 32'd1);
         check("to_rsp_valid_wait", {31'd0, rsp_valid}, 32'd0);
         tick();
      end
      check("to_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("to_rsp_err", {31'd0, rsp_err}, 32'd1);
      check("to_rsp_rdata", rsp_rdata, 32'd0);
      check("to_psel", {31'd0, PSEL}, 32'd0);
      check("to_penable", {31'd0, PENABLE}, 32'd0);
`else
      for (int i = 0; i < 100; i++) tick();
      check("nto_penable", {31'd0, PENABLE}, 32'd1);
      check("nto_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      PREADY = 1'b1;
      tick();
      PREADY = 1'b0;
      check("nto_rsp_valid_done", {31'd0, rsp_valid}, 32'd1);
      check("nto_rsp_rdata", rsp_rdata, 32'hCAFE_F00D);
`endif
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("final_req_ready", {31'd0, req_ready}, 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
